// File: rtl/data_mem_controller.sv
// Round-robin arbiter that funnels per-consumer read/write requests onto one
// external memory port, serving one transaction at a time.
module data_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);

    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_READ_WAIT  = 2'd1;
    localparam logic [1:0] S_WRITE_WAIT = 2'd2;
    localparam logic [1:0] S_RELAY      = 2'd3;

    // Handshake: a requester holds valid (with stable address/data) until it
    // sees ready; ready then stays high until the requester drops valid.
    // Toward memory, mem_*_valid and its payload stay fixed until mem_*_ready.

    logic [1:0]                         state_q, state_d;
    logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]                   grant_q, grant_d;
    logic                               is_write_q, is_write_d;
    logic                               mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]               mem_read_address_q, mem_read_address_d;
    logic                               mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]               mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]               mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]           read_ready_q, read_ready_d;
    logic [NUM_CONSUMERS-1:0]           write_ready_q, write_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;

    logic [NUM_CONSUMERS-1:0] write_req;
    logic                     found;
    logic [PTR_W-1:0]         pick;
    logic                     pick_write;
    logic                     req_held;

    assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

    // Rotating priority scan starting at rr_ptr_q; reads win over writes.
    always_comb begin : scan
        int idx;
        found      = 1'b0;
        pick       = '0;
        pick_write = 1'b0;
        idx        = 0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CONSUMERS) begin
                idx = idx - NUM_CONSUMERS;
            end
            if (!found && (consumer_read_valid[idx[PTR_W-1:0]] || write_req[idx[PTR_W-1:0]])) begin
                found      = 1'b1;
                pick       = idx[PTR_W-1:0];
                pick_write = !consumer_read_valid[idx[PTR_W-1:0]];
            end
        end
    end

    assign req_held = is_write_q ? write_req[grant_q] : consumer_read_valid[grant_q];

    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        grant_d             = grant_q;
        is_write_d          = is_write_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        read_ready_d        = read_ready_q;
        write_ready_d       = write_ready_q;
        read_data_d         = read_data_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    is_write_d = pick_write;
                    if (pick_write) begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
                        mem_write_data_d    = consumer_write_data[int'(pick)*DATA_BITS +: DATA_BITS];
                        state_d             = S_WRITE_WAIT;
                    end else begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
                        state_d            = S_READ_WAIT;
                    end
                end
            end
            S_READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_read_valid_d                                  = 1'b0;
                    read_data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
                    read_ready_d[grant_q]                             = 1'b1;
                    state_d                                           = S_RELAY;
                end
            end
            S_WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_write_valid_d      = 1'b0;
                    write_ready_d[grant_q] = 1'b1;
                    state_d                = S_RELAY;
                end
            end
            S_RELAY: begin
                // A requester that already dropped valid still gets a one-cycle pulse.
                if (!req_held) begin
                    read_ready_d[grant_q]  = 1'b0;
                    write_ready_d[grant_q] = 1'b0;
                    rr_ptr_d               = (int'(grant_q) == NUM_CONSUMERS - 1) ? '0 : grant_q + 1'b1;
                    state_d                = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= S_IDLE;
            rr_ptr_q            <= '0;
            grant_q             <= '0;
            is_write_q          <= 1'b0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            read_ready_q        <= '0;
            write_ready_q       <= '0;
            read_data_q         <= '0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_q             <= grant_d;
            is_write_q          <= is_write_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            read_ready_q        <= read_ready_d;
            write_ready_q       <= write_ready_d;
            read_data_q         <= read_data_d;
        end
    end

    assign consumer_read_ready  = read_ready_q;
    assign consumer_read_data   = read_data_q;
    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign consumer_write_ready = (WRITE_ENABLE != 0) ? write_ready_q : '0;
    assign mem_write_valid      = (WRITE_ENABLE != 0) && mem_write_valid_q;
    assign mem_write_address    = (WRITE_ENABLE != 0) ? mem_write_address_q : '0;
    assign mem_write_data       = (WRITE_ENABLE != 0) ? mem_write_data_q : '0;

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the controller.
module tb_data_mem_controller;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [N-1:0]    crv = '0, cwv = '0, crr, cwr;
    logic [N*AW-1:0] cra = '0, cwa = '0;
    logic [N*DW-1:0] cwd = '0, crd;
    logic            mrv, mwv, mrr = 1'b0, mwr = 1'b0;
    logic [AW-1:0]   mra, mwa;
    logic [DW-1:0]   mrd = '0, mwd;

    logic [N-1:0]    ro_crv = '0, ro_cwv = '0, ro_crr, ro_cwr;
    logic [N*AW-1:0] ro_cra = '0, ro_cwa = '0;
    logic [N*DW-1:0] ro_cwd = '0, ro_crd;
    logic            ro_mrv, ro_mwv, ro_mrr = 1'b0, ro_mwr = 1'b0;
    logic [AW-1:0]   ro_mra, ro_mwa;
    logic [DW-1:0]   ro_mrd = '0, ro_mwd;

    int total = 0;
    int bad   = 0;

    bit chk_en      = 1'b0;
    bit agent_drop  = 1'b0;
    bit agent_raise = 1'b0;
    bit mem_auto    = 1'b0;

    logic [DW-1:0] mem_arr [256];
    logic [AW-1:0] exp_q [$];

    data_mem_controller #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(crv), .consumer_read_address(cra),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(cwv), .consumer_write_address(cwa),
        .consumer_write_data(cwd), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr)
    );

    data_mem_controller #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N), .WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset(reset),
        .consumer_read_valid(ro_crv), .consumer_read_address(ro_cra),
        .consumer_read_ready(ro_crr), .consumer_read_data(ro_crd),
        .consumer_write_valid(ro_cwv), .consumer_write_address(ro_cwa),
        .consumer_write_data(ro_cwd), .consumer_write_ready(ro_cwr),
        .mem_read_valid(ro_mrv), .mem_read_address(ro_mra),
        .mem_read_ready(ro_mrr), .mem_read_data(ro_mrd),
        .mem_write_valid(ro_mwv), .mem_write_address(ro_mwa),
        .mem_write_data(ro_mwd), .mem_write_ready(ro_mwr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One transaction owner at a time: pick by rotating priority, wait for
    // memory, then hold the response until the owner lets go of its request.
    bit              m_busy = 0, m_out = 0, m_wr = 0;
    int              m_ptr = 0, m_owner = 0;
    logic [N-1:0]    e_crr = '0, e_cwr = '0;
    logic [N*DW-1:0] e_crd = '0;
    logic            e_mrv = 0, e_mwv = 0;
    logic [AW-1:0]   e_mra = '0, e_mwa = '0;
    logic [DW-1:0]   e_mwd = '0;

    task automatic model_step();
        if (reset) begin
            m_busy = 0; m_out = 0; m_wr = 0; m_ptr = 0; m_owner = 0;
            e_crr = '0; e_cwr = '0; e_crd = '0;
            e_mrv = 0; e_mwv = 0; e_mra = '0; e_mwa = '0; e_mwd = '0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!m_busy && (crv[c] || cwv[c])) begin
                    m_busy = 1; m_out = 1; m_owner = c;
                    m_wr = !crv[c];
                    if (m_wr) begin
                        e_mwv = 1; e_mwa = cwa[c*AW +: AW]; e_mwd = cwd[c*DW +: DW];
                    end else begin
                        e_mrv = 1; e_mra = cra[c*AW +: AW];
                    end
                end
            end
        end else if (m_out) begin
            if (!m_wr && mrr) begin
                m_out = 0; e_mrv = 0;
                e_crd[m_owner*DW +: DW] = mrd;
                e_crr[m_owner] = 1;
            end else if (m_wr && mwr) begin
                m_out = 0; e_mwv = 0;
                e_cwr[m_owner] = 1;
            end
        end else if (!(m_wr ? cwv[m_owner] : crv[m_owner])) begin
            e_crr[m_owner] = 0;
            e_cwr[m_owner] = 0;
            m_ptr  = (m_owner + 1) % N;
            m_busy = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("crr", crr, e_crr);
            check("cwr", cwr, e_cwr);
            check("crd", crd, e_crd);
            check("mrv", mrv, e_mrv);
            check("mwv", mwv, e_mwv);
            if (e_mrv) check("mra", mra, e_mra);
            if (e_mwv) begin
                check("mwa", mwa, e_mwa);
                check("mwd", mwd, e_mwd);
            end
        end
    end

    // ---------------- consumer agents ----------------
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (agent_drop) begin
                if (crv[i] && crr[i] && $urandom_range(0, 2) != 0) crv[i] = 1'b0;
                if (cwv[i] && cwr[i] && $urandom_range(0, 2) != 0) cwv[i] = 1'b0;
            end
            if (agent_raise) begin
                if (crv[i] && !crr[i] && $urandom_range(0, 99) == 0) crv[i] = 1'b0;
                else if (!crv[i] && !crr[i] && $urandom_range(0, 3) == 0) begin
                    crv[i] = 1'b1;
                    cra[i*AW +: AW] = AW'($urandom_range(0, 255));
                end
                if (cwv[i] && !cwr[i] && $urandom_range(0, 99) == 0) cwv[i] = 1'b0;
                else if (!cwv[i] && !cwr[i] && $urandom_range(0, 3) == 0) begin
                    cwv[i] = 1'b1;
                    cwa[i*AW +: AW] = AW'($urandom_range(0, 255));
                    cwd[i*DW +: DW] = DW'($urandom_range(0, 255));
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        for (int a = 0; a < 256; a++) mem_arr[a] = DW'($urandom_range(0, 255));
        forever begin
            @(negedge clk);
            if (mem_auto) begin
                if (mrr) mrr = 1'b0;
                else if (mrv && $urandom_range(0, 3) == 0) begin
                    mrr = 1'b1; mrd = mem_arr[mra];
                end else if (!mrv && $urandom_range(0, 15) == 0) begin
                    mrr = 1'b1; mrd = DW'($urandom_range(0, 255));
                end
                if (mwr) mwr = 1'b0;
                else if (mwv && $urandom_range(0, 3) == 0) begin
                    mwr = 1'b1; mem_arr[mwa] = mwd;
                end else if (!mwv && $urandom_range(0, 15) == 0) mwr = 1'b1;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic serve_read(input logic [DW-1:0] data, output logic [AW-1:0] addr);
        int n;
        n = 0;
        while (!mrv && n < 40) begin tick(); n++; end
        check("rd_wait", (n < 40), 1);
        addr = mra;
        mrr  = 1'b1; mrd = data;
        tick();
        mrr  = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((crv != 0 || cwv != 0 || crr != 0 || cwr != 0 || mrv || mwv) && n < limit) begin
            tick(); n++;
        end
        check("idle_wait", (n < limit), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic ro_test();
        bit got;
        got = 0;
        ro_cwv = '1; ro_cwa = 32'h11223344; ro_cwd = 32'hAABBCCDD; ro_mwr = 1'b1;
        ro_crv[0] = 1'b1; ro_cra[7:0] = 8'h11;
        for (int t = 0; t < 20; t++) begin
            tick();
            check("ro_mwv", ro_mwv, 0);
            check("ro_cwr", ro_cwr, 0);
            if (ro_mrr) ro_mrr = 1'b0;
            else if (ro_mrv) begin
                check("ro_mra", ro_mra, 8'h11);
                ro_mrr = 1'b1; ro_mrd = 8'h3C;
            end
            if (ro_crv[0] && ro_crr[0]) begin
                got = 1;
                check("ro_crd", ro_crd[7:0], 8'h3C);
                ro_crv[0] = 1'b0;
            end
        end
        check("ro_done", got, 1);
        ro_cwv = '0; ro_mwr = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [AW-1:0] a;
        int n;
        do_reset();
        chk_en = 1'b1;
        check("rst_crr", crr, 0);
        check("rst_crd", crd, 0);
        check("rst_mrv", mrv, 0);

        // Single read, memory answers two cycles after the request appears.
        crv[2] = 1'b1; cra[2*AW +: AW] = 8'h10;
        tick();
        check("t1_mrv", mrv, 1);
        check("t1_mra", mra, 8'h10);
        tick();
        check("t1_crr_early", crr[2], 0);
        tick();
        mrr = 1'b1; mrd = 8'hA5;
        tick();
        mrr = 1'b0;
        check("t1_crr", crr[2], 1);
        check("t1_crd", crd[2*DW +: DW], 8'hA5);
        check("t1_mrv_off", mrv, 0);
        crv[2] = 1'b0;
        tick();
        check("t1_crr_clr", crr[2], 0);
        check("t1_crd_hold", crd[2*DW +: DW], 8'hA5);

        // Round robin from pointer 0; consumer 0 re-requests after its service.
        do_reset();
        agent_drop = 1'b1;
        for (int i = 0; i < N; i++) cra[i*AW +: AW] = AW'(8'h40 + i);
        crv = '1;
        exp_q = {8'h40, 8'h41, 8'h42, 8'h43, 8'h50};
        for (int k = 0; k < 5; k++) begin
            serve_read(DW'(8'h90 + k), a);
            check("rr_order", a, exp_q.pop_front());
            if (k == 0) begin
                n = 0;
                while ((crv[0] || crr[0]) && n < 20) begin tick(); n++; end
                crv[0] = 1'b1; cra[7:0] = 8'h50;
            end
        end
        wait_idle(40);

        // Read and write from the same consumer, then a stalled write.
        crv[1] = 1'b1; cra[1*AW +: AW] = 8'h20;
        cwv[1] = 1'b1; cwa[1*AW +: AW] = 8'h30; cwd[1*DW +: DW] = 8'h7E;
        tick();
        check("t3_mrv", mrv, 1);
        check("t3_mwv", mwv, 0);
        serve_read(8'h11, a);
        check("t3_mra", a, 8'h20);
        n = 0;
        while (!mwv && n < 20) begin tick(); n++; end
        check("t3_wr_wait", (n < 20), 1);
        for (int s = 0; s < 10; s++) begin
            check("t4_mwv", mwv, 1);
            check("t4_mwa", mwa, 8'h30);
            check("t4_mwd", mwd, 8'h7E);
            tick();
        end
        mwr = 1'b1;
        check("t4_cwr_early", cwr[1], 0);
        tick();
        mwr = 1'b0;
        check("t4_cwr", cwr[1], 1);
        check("t4_mwv_off", mwv, 0);
        wait_idle(40);

        // Reset while a read is outstanding, then consumer 3 retries.
        crv[3] = 1'b1; cra[3*AW +: AW] = 8'h33;
        n = 0;
        while (!mrv && n < 20) begin tick(); n++; end
        tick();
        reset = 1'b1;
        tick();
        check("t5_crr", crr, 0);
        check("t5_cwr", cwr, 0);
        check("t5_crd", crd, 0);
        check("t5_mrv", mrv, 0);
        check("t5_mra", mra, 0);
        check("t5_mwv", mwv, 0);
        check("t5_mwa", mwa, 0);
        check("t5_mwd", mwd, 0);
        reset = 1'b0;
        serve_read(8'h5C, a);
        check("t5_mra_retry", a, 8'h33);
        check("t5_crr_retry", crr[3], 1);
        check("t5_crd_retry", crd[3*DW +: DW], 8'h5C);
        wait_idle(40);

        ro_test();

        // Randomized traffic with spurious memory acknowledges.
        mem_auto    = 1'b1;
        agent_raise = 1'b1;
        repeat (3000) tick();
        agent_raise = 1'b0;
        wait_idle(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
